// File: rtl/tinker_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tinker_mem_ctrl
// Description : Byte-addressed, little-endian memory with a 32-bit fetch port
//               and a DATA_BYTES-wide load/store port. One transaction is in
//               flight at a time. Simultaneous requests are arbitrated
//               round-robin. Responses arrive a fixed LATENCY cycles after
//               acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tinker_mem_ctrl #(
  parameter int unsigned MEM_BYTES  = 524288,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  // fetch request / response
  input  logic                      f_req_valid,
  output logic                      f_req_ready,
  input  logic [ADDR_W-1:0]         f_addr,
  output logic                      f_rsp_valid,
  output logic [31:0]               f_rsp_data,
  output logic                      f_rsp_err,
  // data request / response
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic                      d_we,
  input  logic [DATA_BYTES-1:0]     d_be,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [8*DATA_BYTES-1:0]   d_wdata,
  output logic                      d_rsp_valid,
  output logic [8*DATA_BYTES-1:0]   d_rsp_data,
  output logic                      d_rsp_err
);

  localparam int unsigned IDX_W  = $clog2(MEM_BYTES);
  localparam int unsigned DB_LOG = $clog2(DATA_BYTES);

  // One past the last valid byte address, widened so addr+width never wraps.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Control state
  logic [1:0]                state;
  logic [2:0]                cnt;
  // 1: fetch was the last port granted on a tie, so data wins the next tie.
  logic                      rr_last_f;

  // Captured request
  logic                      sel_d;
  logic                      we_q;
  logic                      err_q;
  logic [IDX_W-1:0]          idx_q;
  logic [DATA_BYTES-1:0]     be_q;
  logic [8*DATA_BYTES-1:0]   wdata_q;

  // Storage array; deliberately has no reset so contents survive a reset.
  logic [7:0]                mem [MEM_BYTES];

  // Arbitration and handshake
  logic                      idle;
  logic                      tie;
  logic                      grant_f;
  logic                      grant_d;
  logic                      accept;
  logic                      rsp_active;
  logic                      do_write;

  // Address checks on the incoming request
  logic [ADDR_W:0]           f_end;
  logic [ADDR_W:0]           d_end;
  logic                      f_err;
  logic                      d_err;

  assign idle    = reset && (state == ST_IDLE);
  assign tie     = f_req_valid && d_req_valid;
  assign grant_d = d_req_valid && (!f_req_valid || rr_last_f);
  assign grant_f = f_req_valid && (!d_req_valid || !rr_last_f);

  assign f_req_ready = idle && grant_f;
  assign d_req_ready = idle && grant_d;
  assign accept      = f_req_ready || d_req_ready;

  assign f_end = {1'b0, f_addr} + (ADDR_W+1)'(4);
  assign d_end = {1'b0, d_addr} + (ADDR_W+1)'(DATA_BYTES);
  assign f_err = (f_addr[1:0] != 2'b00) || (f_end > MEM_LIMIT);
  assign d_err = (d_addr[DB_LOG-1:0] != '0) || (d_end > MEM_LIMIT);

  // Sequencer: IDLE -> (WAIT) -> RESP -> IDLE, plus the round-robin bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      rr_last_f <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (tie) begin
              rr_last_f <= grant_f;
            end
            if (LATENCY == 1) begin
              state <= ST_RESP;
              cnt   <= 3'd0;
            end else begin
              state <= ST_WAIT;
              cnt   <= 3'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          // Moving to RESP as the count hits zero puts rsp_valid on the
          // LATENCY-th edge after acceptance.
          if (cnt <= 3'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Capture the accepted request; fetches clear the write-side fields.
  always_ff @(posedge clk) begin
    if (d_req_ready) begin
      sel_d   <= 1'b1;
      we_q    <= d_we;
      be_q    <= d_be;
      wdata_q <= d_wdata;
      idx_q   <= d_addr[IDX_W-1:0];
      err_q   <= d_err;
    end else if (f_req_ready) begin
      sel_d   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= f_addr[IDX_W-1:0];
      err_q   <= f_err;
    end
  end

  assign rsp_active = reset && (state == ST_RESP);
  assign do_write   = rsp_active && sel_d && we_q && !err_q;

  // Byte-enabled store, committed on the edge that ends the RESP cycle.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (be_q[k]) begin
          mem[idx_q + IDX_W'(k)] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign f_rsp_valid = rsp_active && !sel_d;
  assign d_rsp_valid = rsp_active && sel_d;
  assign f_rsp_err   = f_rsp_valid && err_q;
  assign d_rsp_err   = d_rsp_valid && err_q;

  // Read data is taken from the array during RESP and forced to zero otherwise.
  always_comb begin
    f_rsp_data = '0;
    d_rsp_data = '0;
    if (f_rsp_valid && !err_q) begin
      for (int k = 0; k < 4; k++) begin
        f_rsp_data[8*k +: 8] = mem[idx_q + IDX_W'(k)];
      end
    end
    if (d_rsp_valid && !we_q && !err_q) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        d_rsp_data[8*k +: 8] = mem[idx_q + IDX_W'(k)];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tinker_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tinker_mem_ctrl
// Description : Self-checking bench for tinker_mem_ctrl against a byte-array
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tinker_mem_ctrl;

  localparam int unsigned MEMB = 524288;
  localparam int unsigned DB   = 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned W    = 8 * DB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          f_req_valid = 1'b0;
  logic          f_req_ready;
  logic [AW-1:0] f_addr = '0;
  logic          f_rsp_valid;
  logic [31:0]   f_rsp_data;
  logic          f_rsp_err;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic          d_we = 1'b0;
  logic [DB-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [W-1:0]  d_wdata = '0;
  logic          d_rsp_valid;
  logic [W-1:0]  d_rsp_data;
  logic          d_rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model memory
  logic [7:0] mdl [0:MEMB-1];

  always #5 clk = ~clk;

  tinker_mem_ctrl #(
    .MEM_BYTES (MEMB),
    .DATA_BYTES(DB),
    .LATENCY   (LAT),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .f_req_valid(f_req_valid),
    .f_req_ready(f_req_ready),
    .f_addr     (f_addr),
    .f_rsp_valid(f_rsp_valid),
    .f_rsp_data (f_rsp_data),
    .f_rsp_err  (f_rsp_err),
    .d_req_valid(d_req_valid),
    .d_req_ready(d_req_ready),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rsp_valid(d_rsp_valid),
    .d_rsp_data (d_rsp_data),
    .d_rsp_err  (d_rsp_err)
  );

  // ---------------- reference model ----------------
  function automatic void d_model(input logic we, input logic [DB-1:0] be,
                                  input logic [31:0] a, input logic [W-1:0] wd,
                                  output logic [W-1:0] rd, output logic er);
    longint unsigned la;
    la = longint'(a);
    er = ((la % DB) != 0) || (la + DB > MEMB);
    rd = '0;
    if (!er) begin
      for (int k = 0; k < DB; k++) begin
        if (we) begin
          if (be[k]) mdl[la + k] = wd[8*k +: 8];
        end else begin
          rd[8*k +: 8] = mdl[la + k];
        end
      end
    end
  endfunction

  function automatic void f_model(input logic [31:0] a,
                                  output logic [31:0] rd, output logic er);
    longint unsigned la;
    la = longint'(a);
    er = ((la % 4) != 0) || (la + 4 > MEMB);
    rd = '0;
    if (!er) begin
      for (int k = 0; k < 4; k++) rd[8*k +: 8] = mdl[la + k];
    end
  endfunction

  // Mostly in the initialised low window, sometimes near/over the top.
  function automatic logic [31:0] rand_addr(input int unsigned align);
    logic [31:0] a;
    int unsigned r;
    r = $urandom % 8;
    if (r == 0) a = MEMB - 8 + $urandom_range(0, 23);
    else        a = $urandom_range(0, 'h1FF);
    if (r > 1) a = a & ~(align - 1);
    return a;
  endfunction

  // ---------------- transaction drivers ----------------
  task automatic d_txn(input logic we, input logic [DB-1:0] be, input logic [31:0] a,
                       input logic [W-1:0] wd, output int lat,
                       output logic [W-1:0] rd, output logic er);
    int n;
    lat = -1; rd = '0; er = 1'b0;
    @(negedge clk);
    d_we = we; d_be = be; d_addr = a; d_wdata = wd; d_req_valid = 1'b1;
    #1;
    n = 0;
    while (!d_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!d_req_ready) begin d_req_valid = 1'b0; return; end
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; d_req_valid = 1'b0; end
    while (!d_rsp_valid && n < LAT + 6);
    if (d_rsp_valid) begin lat = n; rd = d_rsp_data; er = d_rsp_err; end
  endtask

  task automatic f_txn(input logic [31:0] a, output int lat,
                       output logic [31:0] rd, output logic er);
    int n;
    lat = -1; rd = '0; er = 1'b0;
    @(negedge clk);
    f_addr = a; f_req_valid = 1'b1;
    #1;
    n = 0;
    while (!f_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!f_req_ready) begin f_req_valid = 1'b0; return; end
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; f_req_valid = 1'b0; end
    while (!f_rsp_valid && n < LAT + 6);
    if (f_rsp_valid) begin lat = n; rd = f_rsp_data; er = f_rsp_err; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int bad_rdy, bad_rsp;
    bad_rdy = 0; bad_rsp = 0;
    reset = 1'b0;
    f_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b1; d_be = '1;
    repeat (4) begin
      @(negedge clk); #1;
      if (f_req_ready !== 1'b0 || d_req_ready !== 1'b0) bad_rdy++;
      if (f_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || f_rsp_err !== 1'b0 ||
          d_rsp_err !== 1'b0 || f_rsp_data !== '0 || d_rsp_data !== '0) bad_rsp++;
    end
    n_cmp++;
    if (bad_rdy != 0) begin n_fail++; $display("FAIL reset_ready: %0d cycles with ready high, want 0", bad_rdy); end
    n_cmp++;
    if (bad_rsp != 0) begin n_fail++; $display("FAIL reset_rsp: %0d cycles with response outputs nonzero, want 0", bad_rsp); end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed;
    int lat; logic [W-1:0] rd, mrd; logic er, mer; logic [31:0] frd;
    d_model(1'b1, 8'hFF, 32'h100, 64'h1122334455667788, mrd, mer);
    d_txn(1'b1, 8'hFF, 32'h100, 64'h1122334455667788, lat, rd, er);
    n_cmp++;
    if (lat != LAT || rd !== '0 || er !== 1'b0) begin
      n_fail++; $display("FAIL dir_write: lat=%0d data=%h err=%b, want lat=%0d data=0 err=0", lat, rd, er, LAT);
    end
    d_model(1'b0, 8'h00, 32'h100, '0, mrd, mer);
    d_txn(1'b0, 8'h00, 32'h100, '1, lat, rd, er);
    n_cmp++;
    if (lat != LAT || rd !== 64'h1122334455667788 || er !== 1'b0) begin
      n_fail++; $display("FAIL dir_read: lat=%0d data=%h err=%b, want lat=%0d data=1122334455667788 err=0", lat, rd, er, LAT);
    end
    f_txn(32'h100, lat, frd, er);
    n_cmp++;
    if (frd[7:0] !== 8'h88 || lat != LAT || er !== 1'b0) begin
      n_fail++; $display("FAIL dir_byte100: got %h lat=%0d err=%b, want 88 lat=%0d err=0", frd[7:0], lat, er, LAT);
    end
    d_model(1'b1, 8'h0F, 32'h100, 64'hFFFFFFFFAAAAAAAA, mrd, mer);
    d_txn(1'b1, 8'h0F, 32'h100, 64'hFFFFFFFFAAAAAAAA, lat, rd, er);
    d_txn(1'b0, 8'hFF, 32'h100, '0, lat, rd, er);
    n_cmp++;
    if (rd !== 64'h11223344AAAAAAAA || er !== 1'b0) begin
      n_fail++; $display("FAIL dir_partial: data=%h err=%b, want 11223344aaaaaaaa err=0", rd, er);
    end
    f_txn(32'h104, lat, frd, er);
    n_cmp++;
    if (frd !== 32'h11223344 || er !== 1'b0 || lat != LAT) begin
      n_fail++; $display("FAIL dir_fetch104: data=%h err=%b lat=%0d, want 11223344 err=0 lat=%0d", frd, er, lat, LAT);
    end
  endtask

  task automatic test_init_window;
    int lat, bad; logic [W-1:0] rd, mrd, wd; logic er, mer;
    logic [31:0] a;
    bad = 0;
    for (int i = 0; i <= 64; i++) begin
      a = (i == 64) ? 32'(MEMB - 8) : 32'(i * 8);
      wd = {$urandom, $urandom};
      d_model(1'b1, '1, a, wd, mrd, mer);
      d_txn(1'b1, '1, a, wd, lat, rd, er);
      if (lat != LAT || rd !== mrd || er !== mer) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL init_writes: %0d bad responses, want 0", bad); end
  endtask

  task automatic test_errors;
    int lat; logic [W-1:0] rd, mrd; logic er, mer; logic [31:0] frd, mfrd;
    logic [31:0] dlist [4];
    logic [31:0] flist [4];
    dlist = '{32'h103, 32'(MEMB - 4), 32'h100, 32'(MEMB - 8)};
    for (int i = 0; i < 4; i++) begin
      // first two are bad-address writes, last two read back the neighbours
      d_model(i < 2, '1, dlist[i], '1, mrd, mer);
      d_txn(i < 2, '1, dlist[i], '1, lat, rd, er);
      n_cmp++;
      if (lat != LAT || rd !== mrd || er !== mer) begin
        n_fail++; $display("FAIL err_d[%0d] addr=%h: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                           i, dlist[i], lat, rd, er, LAT, mrd, mer);
      end
    end
    d_model(1'b0, '0, 32'h103, '0, mrd, mer);
    d_txn(1'b0, '0, 32'h103, '0, lat, rd, er);
    n_cmp++;
    if (rd !== '0 || er !== 1'b1) begin
      n_fail++; $display("FAIL err_dread103: data=%h err=%b, want 0 err=1", rd, er);
    end
    flist = '{32'h102, 32'(MEMB - 4), 32'(MEMB), 32'h1FC};
    for (int i = 0; i < 4; i++) begin
      f_model(flist[i], mfrd, mer);
      f_txn(flist[i], lat, frd, er);
      n_cmp++;
      if (lat != LAT || frd !== mfrd || er !== mer) begin
        n_fail++; $display("FAIL err_f[%0d] addr=%h: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                           i, flist[i], lat, frd, er, LAT, mfrd, mer);
      end
    end
  endtask

  task automatic test_withdraw;
    int n, bad; logic [W-1:0] mrd; logic mer;
    bad = 0;
    d_model(1'b0, '0, 32'h40, '0, mrd, mer);
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h40; d_req_valid = 1'b1;
    #1;
    n = 0;
    while (!d_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0;
    f_addr = 32'h0; f_req_valid = 1'b1;
    #1;
    if (f_req_ready !== 1'b0) bad++;
    @(negedge clk);
    f_req_valid = 1'b0;
    n_cmp++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== mrd) begin
      n_fail++; $display("FAIL withdraw_dread: valid=%b data=%h, want 1 %h", d_rsp_valid, d_rsp_data, mrd);
    end
    repeat (8) begin
      @(negedge clk); #1;
      if (f_rsp_valid !== 1'b0 || f_req_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL withdraw_fetch: %0d cycles with fetch activity, want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int n, bad, lat; logic [W-1:0] rd, mrd; logic er, mer;
    bad = 0;
    d_model(1'b0, '0, 32'h100, '0, mrd, mer);
    @(negedge clk);
    d_we = 1'b1; d_be = '1; d_addr = 32'h100; d_wdata = ~mrd; d_req_valid = 1'b1;
    #1;
    n = 0;
    while (!d_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    f_req_valid = 1'b1; f_addr = 32'h0;
    repeat (4) begin
      #1;
      if (f_req_ready !== 1'b0 || d_req_ready !== 1'b0 ||
          f_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    reset = 1'b1;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d cycles with ready/rsp high, want 0", bad); end
    d_txn(1'b0, '0, 32'h100, '0, lat, rd, er);
    n_cmp++;
    if (lat != LAT || rd !== mrd || er !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_unchanged: lat=%0d data=%h err=%b, want lat=%0d data=%h err=0", lat, rd, er, LAT, mrd);
    end
  endtask

  task automatic test_arbitration;
    int n;
    logic got_d, exp_d, mer, er;
    logic [W-1:0] mrd, rd;
    logic [31:0] mfrd;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    d_we = $urandom_range(0, 1); d_be = DB'($urandom); d_addr = rand_addr(DB);
    d_wdata = {$urandom, $urandom}; d_req_valid = 1'b1;
    f_addr = rand_addr(4); f_req_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) @(negedge clk);
      #1;
      n = 0;
      while (!(f_req_ready || d_req_ready) && n < 20) begin @(negedge clk); #1; n++; end
      exp_d = (g % 2 == 0);
      got_d = d_req_ready;
      n_cmp++;
      if (d_req_ready !== exp_d || f_req_ready !== !exp_d) begin
        n_fail++; $display("FAIL arb_grant[%0d]: d_ready=%b f_ready=%b, want d_ready=%b f_ready=%b",
                           g, d_req_ready, f_req_ready, exp_d, !exp_d);
      end
      if (got_d) begin
        d_model(d_we, d_be, d_addr, d_wdata, mrd, mer);
      end else begin
        f_model(f_addr, mfrd, mer);
        mrd = W'(mfrd);
      end
      @(posedge clk);
      n = 0;
      do begin
        @(negedge clk); n++;
        if (n == 1) begin
          // hold valid, present the next request for the port just served
          if (got_d) begin
            d_we = $urandom_range(0, 1); d_be = DB'($urandom); d_addr = rand_addr(DB);
            d_wdata = {$urandom, $urandom};
          end else begin
            f_addr = rand_addr(4);
          end
        end
      end while (!(got_d ? d_rsp_valid : f_rsp_valid) && n < LAT + 6);
      rd = got_d ? d_rsp_data : W'(f_rsp_data);
      er = got_d ? d_rsp_err : f_rsp_err;
      n_cmp++;
      if (n != LAT || rd !== mrd || er !== mer) begin
        n_fail++; $display("FAIL arb_rsp[%0d]: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                           g, n, rd, er, LAT, mrd, mer);
      end
    end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic test_random;
    int lat; logic [W-1:0] rd, mrd, wd; logic er, mer; logic [31:0] a, frd, mfrd;
    logic we; logic [DB-1:0] be;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = rand_addr(4);
        f_model(a, mfrd, mer);
        f_txn(a, lat, frd, er);
        n_cmp++;
        if (lat != LAT || frd !== mfrd || er !== mer) begin
          n_fail++; $display("FAIL rand_f[%0d] addr=%h: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                             i, a, lat, frd, er, LAT, mfrd, mer);
        end
      end else begin
        a = rand_addr(DB); we = $urandom_range(0, 1); be = DB'($urandom);
        wd = {$urandom, $urandom};
        d_model(we, be, a, wd, mrd, mer);
        d_txn(we, be, a, wd, lat, rd, er);
        n_cmp++;
        if (lat != LAT || rd !== mrd || er !== mer) begin
          n_fail++; $display("FAIL rand_d[%0d] we=%b addr=%h: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                             i, we, a, lat, rd, er, LAT, mrd, mer);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_init_window();
    test_errors();
    test_withdraw();
    test_reset_mid();
    test_arbitration();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_fail);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/tinker_mem_ctrl.md
TINKER_MEM_CTRL -- requirements
Module: tinker_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 524288, meaning byte-array size.
REQ-002 SHALL have parameter DATA_BYTES, default 8, meaning data-port width in bytes (power of 2, 4..16).
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from acceptance to response (1..8).
REQ-004 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-005 SHALL run on one clock, with reset synchronous and active-low.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-007 SHALL have port reset, input, 1 bit, meaning the synchronous active-low reset.
REQ-008 SHALL have fetch request ports f_req_valid in 1, f_req_ready out 1, f_addr in ADDR_W.
REQ-009 SHALL have fetch response ports f_rsp_valid out 1, f_rsp_data out 32, f_rsp_err out 1.
REQ-010 SHALL have data request ports d_req_valid in 1, d_req_ready out 1, d_we in 1, d_be in DATA_BYTES, d_addr in ADDR_W, d_wdata in 8*DATA_BYTES.
REQ-011 SHALL have data response ports d_rsp_valid out 1, d_rsp_data out 8*DATA_BYTES, d_rsp_err out 1.

Function
REQ-012 SHALL store bytes little-endian: byte at addr+k maps to data bits [8k+7:8k].
REQ-013 SHALL serve one transaction at a time, using FSM states IDLE -> WAIT -> RESP -> IDLE.
REQ-014 SHALL, in IDLE, assert the ready of the granted port only, combinationally from the valids and the rr bit.
REQ-015 SHALL arbitrate simultaneous f/d valids round-robin: grant the port not granted last (rr bit), then toggle rr; a sole requester wins without toggling rr.
REQ-016 SHALL register address, we, be and wdata on acceptance (valid&&ready); both readies SHALL be low outside IDLE.
REQ-017 SHALL, on acceptance, load counter with LATENCY-1 and enter WAIT, or enter RESP directly if LATENCY==1.
REQ-018 SHALL decrement the counter each WAIT cycle and enter RESP when it reaches 0, so that rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-019 SHALL, in RESP, pulse the granted port's rsp_valid high for exactly one cycle (no backpressure), then return to IDLE; a new acceptance may occur the cycle after RESP.
REQ-020 SHALL flag err (no array write, rsp_data=0) if the address is not aligned (fetch: 4 bytes; data: DATA_BYTES) or if addr+width > MEM_BYTES.
REQ-021 SHALL, for a data write, update only the bytes whose be bit is 1, at the RESP cycle clock edge, and return rsp_data = 0.
REQ-022 SHALL, for a data read, ignore be and return all DATA_BYTES bytes.
REQ-023 SHALL return read data sampled at the RESP cycle, so a read accepted after a write RESP sees the written bytes.
REQ-024 SHALL hold rsp_data and rsp_err at 0 whenever the corresponding rsp_valid is 0.
REQ-025 SHALL treat a request whose valid drops before acceptance as never issued.

Reset
REQ-026 SHALL, when reset==0 at a clk edge, set state=IDLE, counter=0, and rr=fetch-preferred (data granted first on the next tie).
REQ-027 SHALL drive all outputs (readies, rsp_valid, rsp_data, rsp_err) to 0 while reset is low.
REQ-028 SHALL, on reset mid-transaction, abort the transaction without issuing a response or write, and SHALL NOT clear array contents.

Verification
REQ-029 SHALL cover: data write d_addr=0x100, d_be=0xFF, d_wdata=0x1122334455667788, LATENCY=2, then read 0x100 -> d_rsp_valid 2 cycles after each acceptance; read data=0x1122334455667788; byte 0x100 = 0x88.
REQ-030 SHALL cover: partial write d_be=0x0F, d_wdata=0xFFFFFFFFAAAAAAAA over the previous value -> read returns 0x11223344AAAAAAAA.
REQ-031 SHALL cover: fetch f_addr=0x104 after that write -> f_rsp_data=0x11223344, f_rsp_err=0.
REQ-032 SHALL cover: f and d valid together for 4 transactions after reset -> grants are d,f,d,f; no transaction is lost.
REQ-033 SHALL cover: d_addr=0x103 and d_addr=MEM_BYTES-4 with DATA_BYTES=8 -> d_rsp_err=1, d_rsp_data=0, memory unchanged.
REQ-034 SHALL cover: reset low during WAIT of a write -> no rsp_valid, target bytes unchanged, readies 0 until reset high, then IDLE.
